bitonic_topn_merger: RTL and testbench
======================================

Name: bitonic_topn_merger

Overview:
- Pipelined, parametrised successor to the fixed-width bitonic merge stage in the classifier back end.
- Takes two ascending-sorted lists of N {key, payload} entries, one per port, and emits the N smallest or N largest entries in ascending key order.
- Used to merge per-field rule-match candidate lists by priority key.
- Adds per-transaction mode, payload carriage, valid/ready flow control with stall, and a deterministic tie rule.

Parameters:
- N, 8: entries per input list and per output list; power of two, 2..64.
- LOG_N, 3: log2(N).
- KEY_W, 4: priority key width; unsigned.
- PAY_W, 8: payload (rule ID) width.
- Derived: EW = KEY_W + PAY_W bits per entry.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- in_mode  in  1  0 = keep N smallest, 1 = keep N largest.
- in_a  in  [0:N*EW-1]  list A, ascending by key. Entry i sits at bits [i*EW : i*EW+EW-1]; key is the leading KEY_W bits of the entry.
- in_b  in  [0:N*EW-1]  list B, ascending, same packing as in_a.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_mode  out  1  in_mode carried alongside the result.
- out_data  out  [0:N*EW-1]  N selected entries, ascending by key, same packing as the inputs.

Behaviour:
- Reset (asserted low): all stage valid bits, out_valid, out_mode and out_data clear to 0 immediately. Any in-flight transactions are discarded; no partial output follows.
- Pipeline: LOG_N+1 register stages.
  - Stage 0, select: for i in 0..N-1, compare A[i] with B[N-1-i]. Keep the smaller key (mode 0) or the larger key (mode 1). The N survivors form a bitonic sequence.
  - Stages 1..LOG_N, half-cleaners: stage s compares positions j and j+N/2^s within each block of size N/2^(s-1). A swap occurs only if key[j] > key[j+N/2^s] (strict), giving ascending order.
  - Mode, payload and valid travel with each stage.
- Latency: acceptance in cycle t gives out_valid in cycle t+LOG_N+1 when unstalled. Throughput is one transaction per cycle.
- Handshake:
  - Transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - Global advance enable: adv = out_ready || !out_valid. in_ready = adv.
  - While adv = 0, every stage register holds. out_data and out_mode stay stable while out_valid && !out_ready.
  - in_valid low while adv = 1 inserts a bubble (stage valid 0). Bubble data is don't-care but registered.
  - in_ready does not depend combinationally on in_valid.
- Ties:
  - Stage 0 with equal keys: the A entry survives in both modes.
  - Half-cleaners with equal keys: no swap.
  - Result: output is fully deterministic, including payload order among equal keys.
- Arithmetic: unsigned key compares only; payload never affects ordering.
- Inputs not sorted: output is defined by the network (no error flag); this is outside the supported operating envelope.
- Boundaries:
  - All keys equal: output is A unchanged.
  - Keys 0 and 2^KEY_W-1 compare correctly; there is no wrap.
  - out_ready low for many cycles: the pipeline fills and then holds. No loss, no duplication.
  - Reset asserted during a stall: the output clears and the held data is dropped.

Decomposition:
- Shared package, used by the classifier back end:
  - function entry_key(entry): extracts the key field.
  - constants for the entry layout (key-first).
  - localparam EW.
- One natural sub-module: bitonic_cmp_swap. Parameters KEY_W, PAY_W and a MODE_MAX select. Purely combinational; takes two entries, outputs lo/hi with the tie rule. It is instantiated N times in stage 0 and N/2 times per half-cleaner stage.
- Stage registers and flow control stay in the top module.

Test Plan:
1. Basic min merge: N=8, KEY_W=4, payload=key. A keys 0,2,4,6,8,A,C,E; B keys 1,3,5,7,9,B,D,F; mode 0 → after 4 cycles out keys 0..7 ascending, out_mode 0.
2. Max merge: same A/B with mode 1 → out keys 8..F ascending.
3. Tie determinism: A keys all 5 with payloads 0x00..0x07; B keys all 5 with payloads 0x10..0x17; mode 0 → out payloads 0x00..0x07 in order. Mode 1 gives the same result.
4. Back-to-back plus stall:
   - Issue 6 transactions on consecutive cycles, including extremes (all 0x0 vs all 0xF).
   - Hold out_ready low for 10 cycles mid-stream; in_ready must drop in the same cycle as any stalled valid output.
   - All 6 results then appear in order, unchanged, with none lost or duplicated; compare against a scoreboard sort model.
5. Random regression: 10k random sorted pairs, random mode, and random out_ready/in_valid (50% each). Check every output against the reference model, including payload order under the tie rule.
6. Async reset: assert reset low mid-stream, away from a clock edge → out_valid and out_data go to 0 immediately. After release, the first new transaction emerges after exactly 4 cycles with correct data and no stale result.

Source files
------------

// File: rtl/bitonic_topn_merger_pkg.sv
// bitonic_topn_merger_pkg: entry layout shared with the classifier back end.
// Entries are key-first: the key occupies the most significant bits of an entry.
package bitonic_topn_merger_pkg;
    localparam int KEY_W_DEF = 4;
    localparam int PAY_W_DEF = 8;
    localparam int EW = KEY_W_DEF + PAY_W_DEF;
    localparam int MAX_W = 64;
    typedef enum logic {MODE_MIN = 1'b0, MODE_MAX = 1'b1} mode_e;
    function automatic logic [MAX_W-1:0] entry_key(input logic [MAX_W-1:0] e, input int ew, input int kw);
        return (e >> (ew - kw)) & ((MAX_W'(1) << kw) - MAX_W'(1));
    endfunction
endpackage

// File: rtl/bitonic_cmp_swap.sv
// bitonic_cmp_swap: ascending compare-exchange; swaps only on a strictly larger key.
// With mode_max set the operands are exchanged first, so on equal keys hi carries a.
module bitonic_cmp_swap
    import bitonic_topn_merger_pkg::*;
#(
    parameter int KEY_W = 4,
    parameter int PAY_W = 8
) (
    input  logic [KEY_W+PAY_W-1:0] a,
    input  logic [KEY_W+PAY_W-1:0] b,
    input  logic                   mode_max,
    output logic [KEY_W+PAY_W-1:0] lo,
    output logic [KEY_W+PAY_W-1:0] hi
);
    localparam int W = KEY_W + PAY_W;
    logic [W-1:0] x, y;
    logic swap;
    always_comb begin
        x = mode_max ? b : a;
        y = mode_max ? a : b;
        swap = entry_key(MAX_W'(x), W, KEY_W) > entry_key(MAX_W'(y), W, KEY_W);
        lo = swap ? y : x;
        hi = swap ? x : y;
    end
endmodule

// File: rtl/bitonic_topn_merger.sv
// bitonic_topn_merger: keeps the N smallest or largest of two ascending lists,
// emitted ascending through a select stage and LOG_N half-cleaner stages.
module bitonic_topn_merger
    import bitonic_topn_merger_pkg::*;
#(
    parameter int N     = 8,
    parameter int LOG_N = 3,
    parameter int KEY_W = 4,
    parameter int PAY_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_mode,
    input  logic [0:N*(KEY_W+PAY_W)-1]   in_a,
    input  logic [0:N*(KEY_W+PAY_W)-1]   in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_mode,
    output logic [0:N*(KEY_W+PAY_W)-1]   out_data
);
    localparam int W = KEY_W + PAY_W;
    logic adv;
    logic [W-1:0] lo0 [N];
    logic [W-1:0] hi0 [N];
    logic [W-1:0] sel [N];
    logic [W-1:0] nxt [LOG_N][N];
    logic [W-1:0] d [LOG_N+1][N];
    logic [LOG_N:0] vld, md;

    // the whole pipeline moves together whenever the output slot can be vacated
    assign adv = out_ready || !out_valid;
    assign in_ready = adv;
    assign out_valid = vld[LOG_N];
    assign out_mode = md[LOG_N];

    for (genvar i = 0; i < N; i++) begin : g_sel
        bitonic_cmp_swap #(.KEY_W(KEY_W), .PAY_W(PAY_W)) u_cs (
            .a(in_a[i*W +: W]),
            .b(in_b[(N-1-i)*W +: W]),
            .mode_max(in_mode),
            .lo(lo0[i]),
            .hi(hi0[i])
        );
        assign sel[i] = (in_mode == MODE_MAX) ? hi0[i] : lo0[i];
        assign out_data[i*W +: W] = d[LOG_N][i];
    end

    for (genvar s = 1; s <= LOG_N; s++) begin : g_hc
        for (genvar k = 0; k < N/2; k++) begin : g_cs
            localparam int H = N >> s;
            localparam int J = (k / H) * 2 * H + k % H;
            bitonic_cmp_swap #(.KEY_W(KEY_W), .PAY_W(PAY_W)) u_cs (
                .a(d[s-1][J]),
                .b(d[s-1][J+H]),
                .mode_max(1'b0),
                .lo(nxt[s-1][J]),
                .hi(nxt[s-1][J+H])
            );
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            md <= '0;
            for (int s = 0; s <= LOG_N; s++)
                for (int i = 0; i < N; i++)
                    d[s][i] <= '0;
        end else if (adv) begin
            vld <= {vld[LOG_N-1:0], in_valid};
            md <= {md[LOG_N-1:0], in_mode};
            for (int i = 0; i < N; i++)
                d[0][i] <= sel[i];
            for (int s = 1; s <= LOG_N; s++)
                for (int i = 0; i < N; i++)
                    d[s][i] <= nxt[s-1][i];
        end
    end
endmodule

// File: tb/tb_bitonic_topn_merger.sv
// tb_bitonic_topn_merger: directed and randomized checks against a sort model and
// an array-level model of the select/half-cleaner rules for payload order on ties.
module tb_bitonic_topn_merger;
    localparam int N = 8;
    localparam int LOG_N = 3;
    localparam int KEY_W = 4;
    localparam int PAY_W = 8;
    localparam int W = KEY_W + PAY_W;
    localparam int DW = N * W;
    localparam int KW = N * KEY_W;
    typedef logic [0:DW-1] vec_t;
    typedef struct {
        vec_t d;
        logic m;
        logic [KW-1:0] k;
    } exp_t;

    logic clk = 0;
    logic reset = 1;
    logic in_valid = 0;
    logic in_ready;
    logic in_mode = 0;
    vec_t in_a = '0;
    vec_t in_b = '0;
    logic out_valid;
    logic out_ready = 0;
    logic out_mode;
    vec_t out_data;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int n_out = 0;
    logic held_v = 0;
    vec_t held_d;

    always #5 clk = ~clk;

    bitonic_topn_merger #(.N(N), .LOG_N(LOG_N), .KEY_W(KEY_W), .PAY_W(PAY_W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mode(in_mode),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mode(out_mode),
        .out_data(out_data)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input int k0, input int ks, input int p0, input int ps);
        vec_t v;
        for (int i = 0; i < N; i++)
            v[i*W +: W] = {KEY_W'(k0 + i*ks), PAY_W'(p0 + i*ps)};
        return v;
    endfunction

    function automatic vec_t rand_list(input int kmax);
        int ks[$];
        vec_t v;
        for (int i = 0; i < N; i++)
            ks.push_back(int'($urandom_range(kmax, 0)));
        ks.sort();
        for (int i = 0; i < N; i++)
            v[i*W +: W] = {KEY_W'(ks[i]), PAY_W'($urandom)};
        return v;
    endfunction

    function automatic logic [KEY_W-1:0] key_of(input logic [W-1:0] e);
        return e[W-1 -: KEY_W];
    endfunction

    // select rule then half-cleaners, applied to an array of entries
    function automatic vec_t ref_net(input vec_t a, input vec_t b, input logic m);
        logic [W-1:0] e[N];
        logic [W-1:0] ea, eb, t;
        vec_t r;
        int h;
        for (int i = 0; i < N; i++) begin
            ea = a[i*W +: W];
            eb = b[(N-1-i)*W +: W];
            e[i] = (m ? key_of(eb) > key_of(ea) : key_of(eb) < key_of(ea)) ? eb : ea;
        end
        for (int s = 1; s <= LOG_N; s++) begin
            h = N >> s;
            for (int j = 0; j < N; j++)
                if ((j / h) % 2 == 0 && key_of(e[j]) > key_of(e[j+h])) begin
                    t = e[j];
                    e[j] = e[j+h];
                    e[j+h] = t;
                end
        end
        for (int i = 0; i < N; i++)
            r[i*W +: W] = e[i];
        return r;
    endfunction

    function automatic logic [KW-1:0] ref_keys(input vec_t a, input vec_t b, input logic m);
        int ks[$];
        logic [KW-1:0] r;
        for (int i = 0; i < N; i++) begin
            ks.push_back(int'(key_of(a[i*W +: W])));
            ks.push_back(int'(key_of(b[i*W +: W])));
        end
        ks.sort();
        for (int i = 0; i < N; i++)
            r[(N-1-i)*KEY_W +: KEY_W] = KEY_W'(m ? ks[N+i] : ks[i]);
        return r;
    endfunction

    function automatic logic [KW-1:0] out_keys(input vec_t v);
        logic [KW-1:0] r;
        for (int i = 0; i < N; i++)
            r[(N-1-i)*KEY_W +: KEY_W] = key_of(v[i*W +: W]);
        return r;
    endfunction

    task automatic step(input logic iv, input logic orr, input logic m, input vec_t a, input vec_t b,
                        output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid = iv;
        out_ready = orr;
        in_mode = m;
        in_a = a;
        in_b = b;
        #1;
        chk("in_ready", DW'(in_ready), DW'(out_ready || !out_valid));
        if (held_v)
            chk("hold_data", out_data, held_d);
        held_v = out_valid && !out_ready;
        held_d = out_data;
        if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0)
                chk("extra_out", DW'(1), DW'(0));
            else begin
                e = q.pop_front();
                chk("data", out_data, e.d);
                chk("mode", DW'(out_mode), DW'(e.m));
                chk("sorted_keys", DW'(out_keys(out_data)), DW'(e.k));
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            e.d = ref_net(a, b, m);
            e.m = m;
            e.k = ref_keys(a, b, m);
            q.push_back(e);
        end
    endtask

    task automatic one_shot(input vec_t a, input vec_t b, input logic m);
        logic acc;
        int lat;
        step(1'b1, 1'b1, m, a, b, acc);
        chk("accept", DW'(acc), DW'(1));
        lat = 0;
        while (lat < 20) begin
            lat++;
            step(1'b0, 1'b1, 1'b0, '0, '0, acc);
            if (out_valid) break;
        end
        chk("latency", DW'(lat), DW'(LOG_N + 1));
    endtask

    task automatic drain();
        logic acc;
        int c;
        c = 0;
        while (q.size() > 0 && c < 200) begin
            c++;
            step(1'b0, 1'b1, 1'b0, '0, '0, acc);
        end
        chk("drain", DW'(q.size()), DW'(0));
    endtask

    initial begin
        vec_t ta[6];
        vec_t tb[6];
        logic tm[6];
        logic acc;
        int sent, base, acc_n, km;
        #1 reset = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_mode", DW'(out_mode), DW'(0));
        chk("rst_data", out_data, '0);
        chk("rst_ready", DW'(in_ready), DW'(1));
        reset = 1;

        one_shot(mk(0, 2, 0, 2), mk(1, 2, 1, 2), 1'b0);
        chk("t1_data", out_data, mk(0, 1, 0, 1));
        chk("t1_mode", DW'(out_mode), DW'(0));
        one_shot(mk(0, 2, 0, 2), mk(1, 2, 1, 2), 1'b1);
        chk("t2_data", out_data, mk(8, 1, 8, 1));
        chk("t2_mode", DW'(out_mode), DW'(1));
        one_shot(mk(5, 0, 0, 1), mk(5, 0, 16, 1), 1'b0);
        chk("t3_min", out_data, mk(5, 0, 0, 1));
        one_shot(mk(5, 0, 0, 1), mk(5, 0, 16, 1), 1'b1);
        chk("t3_max", out_data, mk(5, 0, 0, 1));
        drain();

        ta[0] = mk(0, 0, 0, 1);
        tb[0] = mk(15, 0, 32, 1);
        tm[0] = 1'b0;
        ta[1] = mk(0, 0, 0, 1);
        tb[1] = mk(15, 0, 32, 1);
        tm[1] = 1'b1;
        for (int i = 2; i < 6; i++) begin
            ta[i] = rand_list(15);
            tb[i] = rand_list(15);
            tm[i] = 1'($urandom_range(1, 0));
        end
        sent = 0;
        base = n_out;
        for (int c = 0; c < 60 && (sent < 6 || q.size() > 0); c++) begin
            step(sent < 6, !(c >= 3 && c < 13), tm[sent < 6 ? sent : 0], ta[sent < 6 ? sent : 0],
                 tb[sent < 6 ? sent : 0], acc);
            if (acc) sent++;
        end
        chk("t4_sent", DW'(sent), DW'(6));
        chk("t4_count", DW'(n_out - base), DW'(6));
        drain();

        acc_n = 0;
        for (int c = 0; c < 60000 && acc_n < 10000; c++) begin
            km = $urandom_range(1, 0) ? 15 : 3;
            step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 rand_list(km), rand_list(km), acc);
            if (acc) acc_n++;
        end
        chk("t5_count", DW'(acc_n), DW'(10000));
        drain();

        for (int c = 0; c < 6; c++)
            step(1'b1, 1'b0, 1'($urandom_range(1, 0)), rand_list(15), rand_list(15), acc);
        chk("t6_stalled", DW'(out_valid), DW'(1));
        @(posedge clk);
        #2;
        reset = 0;
        in_valid = 0;
        #1;
        chk("t6_valid", DW'(out_valid), DW'(0));
        chk("t6_data", out_data, '0);
        chk("t6_mode", DW'(out_mode), DW'(0));
        q.delete();
        held_v = 0;
        @(negedge clk);
        #2 reset = 1;
        one_shot(rand_list(15), rand_list(15), 1'b1);
        repeat (8) step(1'b0, 1'b1, 1'b0, '0, '0, acc);
        chk("t6_empty", DW'(q.size()), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
